// File: rtl/sram8_responder.sv
// 16-bit bus responder serving byte/halfword transfers from an 8-bit async SRAM.
// Each transaction runs one or two byte phases of WAIT_STATES+1 cycles, then a one-cycle ack.
module sram8_responder #(
  parameter int ADR_W       = 20,
  parameter int WAIT_STATES = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [63:0]      s_adr_i,
  input  logic             s_cyc_i,
  input  logic             s_stb_i,
  input  logic             s_we_i,
  input  logic             s_siz_i,
  input  logic             s_signed_i,
  input  logic [15:0]      s_dat_i,
  output logic             s_ack_o,
  output logic [15:0]      s_dat_o,
  output logic [ADR_W-1:0] sram_adr_o,
  output logic [7:0]       sram_dat_o,
  input  logic [7:0]       sram_dat_i,
  output logic             sram_dat_oe_o,
  output logic             sram_oe_o,
  output logic             sram_we_o
);
  typedef enum logic [1:0] {IDLE, PH0, PH1, ACK} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [ADR_W-1:0] adr_reg, adr_next;
  logic             we_reg, we_next;
  logic             siz_reg, siz_next;
  logic             sgn_reg, sgn_next;
  logic [15:0]      wdat_reg, wdat_next;
  logic [15:0]      rd_reg, rd_next;

  logic             in_phase;
  logic             ack_next;
  logic [15:0]      s_dat_next;
  logic [ADR_W-1:0] sram_adr_next;
  logic [7:0]       sram_dat_next;
  logic             sram_dat_oe_next;
  logic             sram_oe_next;
  logic             sram_we_next;

  // Next-state, counter and latched request
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    adr_next   = adr_reg;
    we_next    = we_reg;
    siz_next   = siz_reg;
    sgn_next   = sgn_reg;
    wdat_next  = wdat_reg;
    rd_next    = rd_reg;
    unique case (state_reg)
      IDLE: begin
        if (s_cyc_i && s_stb_i) begin
          // Halfwords are always even-aligned on the SRAM side
          adr_next   = s_adr_i[ADR_W-1:0] & ~ADR_W'(s_siz_i);
          we_next    = s_we_i;
          siz_next   = s_siz_i;
          sgn_next   = s_signed_i;
          wdat_next  = s_dat_i;
          cnt_next   = WS;
          state_next = PH0;
        end
      end
      PH0, PH1: begin
        if (!s_cyc_i) begin
          state_next = IDLE;
        end else if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          if (!we_reg) begin
            if (state_reg == PH0) rd_next[7:0]  = sram_dat_i;
            else                  rd_next[15:8] = sram_dat_i;
          end
          if (state_reg == PH0 && siz_reg) begin
            state_next = PH1;
            cnt_next   = WS;
          end else begin
            state_next = ACK;
          end
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are computed from the next state so that every port is a flop
  always_comb begin
    in_phase      = (state_next == PH0) || (state_next == PH1);
    sram_adr_next = sram_adr_o;
    sram_dat_next = sram_dat_o;
    s_dat_next    = s_dat_o;
    if (in_phase) begin
      sram_adr_next = (state_next == PH1) ? (adr_next | ADR_W'(1)) : adr_next;
      if (we_next) sram_dat_next = (state_next == PH1) ? wdat_next[15:8] : wdat_next[7:0];
    end
    sram_oe_next     = in_phase && !we_next;
    sram_dat_oe_next = in_phase && we_next;
    // Strobe drops in the last cycle of the phase for address/data hold
    sram_we_next     = sram_dat_oe_next && (cnt_next != 4'd0);
    ack_next         = (state_next == ACK);
    if (state_next == ACK && !we_reg) begin
      s_dat_next = siz_reg ? rd_next : {{8{sgn_reg & rd_next[7]}}, rd_next[7:0]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      adr_reg       <= '0;
      we_reg        <= 1'b0;
      siz_reg       <= 1'b0;
      sgn_reg       <= 1'b0;
      wdat_reg      <= 16'd0;
      rd_reg        <= 16'd0;
      s_ack_o       <= 1'b0;
      s_dat_o       <= 16'd0;
      sram_adr_o    <= '0;
      sram_dat_o    <= 8'd0;
      sram_dat_oe_o <= 1'b0;
      sram_oe_o     <= 1'b0;
      sram_we_o     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      adr_reg       <= adr_next;
      we_reg        <= we_next;
      siz_reg       <= siz_next;
      sgn_reg       <= sgn_next;
      wdat_reg      <= wdat_next;
      rd_reg        <= rd_next;
      s_ack_o       <= ack_next;
      s_dat_o       <= s_dat_next;
      sram_adr_o    <= sram_adr_next;
      sram_dat_o    <= sram_dat_next;
      sram_dat_oe_o <= sram_dat_oe_next;
      sram_oe_o     <= sram_oe_next;
      sram_we_o     <= sram_we_next;
    end
  end
endmodule
